mmul_operand_loader: RTL and testbench

- Upstream stage of the 3x3 signed 8-bit matrix multiplier.
- Accepts matrix elements one per beat over a valid/ready byte stream, first all of A then all of B, and packs them into the two flat 72-bit operand buses.
- Presents the packed pair with a valid/ready handshake; the multiplier-control glue takes it, pulses enable and waits for done.
- Also detects framing errors using in_last.

---
 rtl/mmul_pkg.sv | 17 +
 rtl/mmul_elem_index.sv | 40 ++++
 rtl/mmul_operand_loader.sv | 108 ++++++++++
 tb/tb_mmul_operand_loader.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mmul_pkg.sv
// rtl/mmul_pkg.sv - shared constants and types for the 3x3 signed matrix multiplier
package mmul_pkg;
   localparam int ELEM_W = 8;
   localparam int DIM    = 3;
   localparam int NELEM  = DIM * DIM;
   localparam int MAT_W  = NELEM * ELEM_W;
   localparam int IDX_W  = $clog2(NELEM);
   localparam int CNT_W  = $clog2(DIM);

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      HOLD   = 2'd2
   } ld_state_t;

   typedef logic signed [ELEM_W-1:0] elem_t;
endpackage

// File: rtl/mmul_elem_index.sv
// rtl/mmul_elem_index.sv - row/col beat counters yielding the bus slot and last-element flag
module mmul_elem_index
   import mmul_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             adv,
   input  logic             transpose,
   output logic [IDX_W-1:0] slot,
   output logic             last_elem
);
   logic [CNT_W-1:0] inner;
   logic [CNT_W-1:0] outer;

   // Slot tracks incrementally: +1 row-major, +DIM column-major, restarting at the next column.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         inner <= '0;
         outer <= '0;
         slot  <= '0;
      end else if (adv) begin
         if (inner == CNT_W'(DIM - 1)) begin
            inner <= '0;
            if (outer == CNT_W'(DIM - 1)) begin
               outer <= '0;
               slot  <= '0;
            end else begin
               outer <= outer + CNT_W'(1);
               slot  <= transpose ? (IDX_W'(outer) + IDX_W'(1)) : (slot + IDX_W'(1));
            end
         end else begin
            inner <= inner + CNT_W'(1);
            slot  <= transpose ? (slot + IDX_W'(DIM)) : (slot + IDX_W'(1));
         end
      end
   end

   assign last_elem = (inner == CNT_W'(DIM - 1)) && (outer == CNT_W'(DIM - 1));
endmodule

// File: rtl/mmul_operand_loader.sv
// rtl/mmul_operand_loader.sv - packs A then B element beats into operand buses; MMUL_OPERAND_LOADER_TRANSPOSE_B_EN takes B column-major
module mmul_operand_loader
   import mmul_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic [ELEM_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [MAT_W-1:0]  mat_a,
   output logic [MAT_W-1:0]  mat_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              frame_err
);
   ld_state_t        state, state_n;
   logic             accept, wr_en, idx_clr, idx_adv, err_n, ov_n;
   logic             last_elem, transpose_b;
   logic [IDX_W-1:0] slot;

   assign in_ready = !reset && (state != HOLD);
   assign accept   = in_valid && in_ready;

`ifdef MMUL_OPERAND_LOADER_TRANSPOSE_B_EN
   assign transpose_b = (state == LOAD_B);
`else
   assign transpose_b = 1'b0;
`endif

   mmul_elem_index u_index (
      .clk       (clk),
      .reset     (reset),
      .clr       (idx_clr),
      .adv       (idx_adv),
      .transpose (transpose_b),
      .slot      (slot),
      .last_elem (last_elem)
   );

   always_comb begin
      state_n = state;
      idx_clr = 1'b0;
      idx_adv = 1'b0;
      wr_en   = 1'b0;
      err_n   = 1'b0;
      ov_n    = out_valid;
      case (state)
         LOAD_A, LOAD_B: begin
            if (clear) begin
               state_n = LOAD_A;
               idx_clr = 1'b1;
            end else if (accept) begin
               // Early last: drop the beat and restart framing from A.
               if (in_last && !(state == LOAD_B && last_elem)) begin
                  err_n   = 1'b1;
                  state_n = LOAD_A;
                  idx_clr = 1'b1;
               end else begin
                  wr_en   = 1'b1;
                  idx_adv = 1'b1;
                  if (last_elem) begin
                     if (state == LOAD_A) begin
                        state_n = LOAD_B;
                     end else begin
                        state_n = HOLD;
                        ov_n    = 1'b1;
                        err_n   = !in_last;
                     end
                  end
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_n = LOAD_A;
               ov_n    = 1'b0;
            end
         end
         default: begin
            state_n = LOAD_A;
            idx_clr = 1'b1;
            ov_n    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= LOAD_A;
         mat_a     <= '0;
         mat_b     <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         out_valid <= ov_n;
         frame_err <= err_n;
         for (int k = 0; k < NELEM; k++) begin
            if (wr_en && slot == IDX_W'(k)) begin
               if (state == LOAD_A) mat_a[k*ELEM_W +: ELEM_W] <= in_data;
               else                 mat_b[k*ELEM_W +: ELEM_W] <= in_data;
            end
         end
      end
   end
endmodule

// File: tb/tb_mmul_operand_loader.sv
// tb/tb_mmul_operand_loader.sv - directed self-checking bench for mmul_operand_loader
module tb_mmul_operand_loader;
   logic        clk = 1'b0;
   logic        reset, clear, in_valid, in_last, out_ready;
   logic [7:0]  in_data;
   logic        in_ready, out_valid, frame_err;
   logic [71:0] mat_a, mat_b;

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  a [9];
   logic [7:0]  b [9];
   logic [71:0] exp_a, exp_b;

   mmul_operand_loader dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .mat_a     (mat_a),
      .mat_b     (mat_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Beat n of B carries element (i,j) row-major, or (j,i)'s position when B is column-major.
   function automatic logic [71:0] pack_a();
      logic [71:0] r = '0;
      for (int k = 0; k < 9; k++) r[k*8 +: 8] = a[k];
      return r;
   endfunction

   function automatic logic [71:0] pack_b();
      logic [71:0] r = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
`ifdef MMUL_OPERAND_LOADER_TRANSPOSE_B_EN
            r[(i*3+j)*8 +: 8] = b[j*3+i];
`else
            r[(i*3+j)*8 +: 8] = b[i*3+j];
`endif
         end
      return r;
   endfunction

   // Called at a negedge; returns at the negedge after the beat is accepted.
   task automatic send(input logic [7:0] d, input logic l);
      int t = 0;
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         checks++;
         failures++;
         $error("FAIL send_timeout observed=in_ready_low expected=in_ready_high");
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic load_pair(input bit gaps, input bit last_ok);
      for (int n = 0; n < 18; n++) begin
         if (gaps && $urandom_range(0, 1) == 1) @(negedge clk);
         send(n < 9 ? a[n] : b[n-9], (n == 17) && last_ok);
      end
      exp_a = pack_a();
      exp_b = pack_b();
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      in_data = '0; out_ready = 1'b0;
      @(negedge clk);
      chk("in_ready_in_reset", {71'd0, in_ready}, 72'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mat_a", mat_a, 72'd0);
      chk("rst_mat_b", mat_b, 72'd0);
      chk("rst_out_valid", {71'd0, out_valid}, 72'd0);
      chk("rst_frame_err", {71'd0, frame_err}, 72'd0);
      chk("rst_in_ready", {71'd0, in_ready}, 72'd1);

      // Basic row-major load, consumer ready throughout
      out_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin a[k] = 8'(k + 1); b[k] = 8'(9 - k); end
      load_pair(1'b0, 1'b1);
      chk("t1_out_valid", {71'd0, out_valid}, 72'd1);
      chk("t1_mat_a", mat_a, exp_a);
      chk("t1_mat_b", mat_b, exp_b);
      chk("t1_a00", {64'd0, mat_a[7:0]}, 72'd1);
      chk("t1_a22", {64'd0, mat_a[71:64]}, 72'd9);
      chk("t1_frame_err", {71'd0, frame_err}, 72'd0);
      @(negedge clk);
      chk("t1_released", {71'd0, out_valid}, 72'd0);
      chk("t1_ready_after", {71'd0, in_ready}, 72'd1);

      // Back-pressure: HOLD for 5 cycles, clear during HOLD ignored
      out_ready = 1'b0;
      for (int k = 0; k < 9; k++) begin a[k] = 8'(10 + k); b[k] = 8'(-(k + 1)); end
      load_pair(1'b0, 1'b1);
      for (int c = 0; c < 5; c++) begin
         clear = (c == 2);
         chk("t2_hold_valid", {71'd0, out_valid}, 72'd1);
         chk("t2_hold_ready", {71'd0, in_ready}, 72'd0);
         chk("t2_hold_a", mat_a, exp_a);
         chk("t2_hold_b", mat_b, exp_b);
         @(negedge clk);
      end
      clear = 1'b0;
      chk("t2_after_clear_valid", {71'd0, out_valid}, 72'd1);
      out_ready = 1'b1;
      @(negedge clk);
      chk("t2_release_valid", {71'd0, out_valid}, 72'd0);
      chk("t2_release_ready", {71'd0, in_ready}, 72'd1);

      // Early last on beat 4, then a clean -128/127 pair
      for (int n = 0; n < 3; n++) send(8'hAA, 1'b0);
      send(8'hBB, 1'b1);
      chk("t3_frame_err_pulse", {71'd0, frame_err}, 72'd1);
      chk("t3_no_valid", {71'd0, out_valid}, 72'd0);
      @(negedge clk);
      chk("t3_frame_err_clear", {71'd0, frame_err}, 72'd0);
      out_ready = 1'b0;
      for (int k = 0; k < 9; k++) begin
         a[k] = k[0] ? 8'h7F : 8'h80;
         b[k] = k[0] ? 8'h80 : 8'h7F;
      end
      load_pair(1'b0, 1'b1);
      chk("t3_mat_a", mat_a, exp_a);
      chk("t3_mat_b", mat_b, exp_b);
      chk("t3_frame_err_clean", {71'd0, frame_err}, 72'd0);
      out_ready = 1'b1;
      @(negedge clk);

      // clear together with early last at beat 12: abort, no frame_err
      out_ready = 1'b0;
      for (int n = 0; n < 11; n++) send(8'h55, 1'b0);
      clear = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_data = 8'h66;
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      chk("t4_clear_no_err", {71'd0, frame_err}, 72'd0);
      chk("t4_clear_no_valid", {71'd0, out_valid}, 72'd0);
      for (int k = 0; k < 9; k++) begin a[k] = 8'(30 + k); b[k] = 8'(60 + 3 * k); end
      load_pair(1'b0, 1'b1);
      chk("t4_mat_a", mat_a, exp_a);
      chk("t4_mat_b", mat_b, exp_b);
      out_ready = 1'b1;
      @(negedge clk);

      // Missing last on beat 18: stored, HOLD reached, frame_err pulses
      out_ready = 1'b0;
      for (int k = 0; k < 9; k++) begin a[k] = 8'(100 + k); b[k] = 8'(200 + k); end
      load_pair(1'b0, 1'b0);
      chk("t5_missing_last_err", {71'd0, frame_err}, 72'd1);
      chk("t5_valid", {71'd0, out_valid}, 72'd1);
      chk("t5_mat_b", mat_b, exp_b);
      @(negedge clk);
      chk("t5_err_one_cycle", {71'd0, frame_err}, 72'd0);
      out_ready = 1'b1;
      @(negedge clk);

      // Random data with random in_valid gaps and back-pressure
      for (int it = 0; it < 3; it++) begin
         out_ready = 1'b0;
         for (int k = 0; k < 9; k++) begin a[k] = 8'($urandom); b[k] = 8'($urandom); end
         load_pair(1'b1, 1'b1);
         repeat ($urandom_range(0, 4)) @(negedge clk);
         chk("t6_valid", {71'd0, out_valid}, 72'd1);
         chk("t6_mat_a", mat_a, exp_a);
         chk("t6_mat_b", mat_b, exp_b);
         out_ready = 1'b1;
         @(negedge clk);
         chk("t6_released", {71'd0, out_valid}, 72'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
